wb_regfile: RTL and testbench

- Write-back stage plus architectural register file, directly downstream of the MEM/WB pipeline register.
- Consumes the MEM/WB outputs (IR, A3, AO, DR, PCp4, RegWrite, MemtoReg, Link).
- Performs load-data extraction and extension, and selects the write-back value.
- Writes the 32x32 GPR array and serves the two ID-stage read ports.
- Keeps a retired-instruction counter.

---
 rtl/mips_defs.sv | 10 +
 rtl/load_ext.sv | 21 ++
 rtl/wb_regfile.sv | 69 ++++++
 tb/tb_wb_regfile.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// mips_defs: opcode and register-index constants shared by the write-back stage.
package mips_defs;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_RA   = 5'd31;
endpackage

// File: rtl/load_ext.sv
// load_ext: little-endian byte/halfword extraction and sign/zero extension of a loaded word.
module load_ext
   import mips_defs::*;
(
   input  logic [31:0] dr_i,
   input  logic [1:0]  addr_i,
   input  logic [5:0]  op_i,
   output logic [31:0] ext_o
);
   logic [7:0]  byte_w;
   logic [15:0] half_w;
   always_comb begin
      byte_w = dr_i[{addr_i, 3'b000} +: 8];
      half_w = addr_i[1] ? dr_i[31:16] : dr_i[15:0];
      // lw and unknown opcodes pass the raw word through
      ext_o  = (op_i == OP_LB)  ? {{24{byte_w[7]}}, byte_w} :
               (op_i == OP_LBU) ? {24'h0, byte_w} :
               (op_i == OP_LH)  ? {{16{half_w[15]}}, half_w} :
               (op_i == OP_LHU) ? {16'h0, half_w} : dr_i;
   end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: write-back mux, 32x32 GPR file with two read ports, retired-instruction counter.
// Optional same-cycle write-through to the read ports when WB_REG_BYPASS_EN is defined.
module wb_regfile
   import mips_defs::*;
#(
   parameter int NREG  = 32,
   parameter int CNT_W = 32
) (
   input  logic             CLK,
   input  logic             reset,
   input  logic [31:0]      IR,
   input  logic [4:0]       A3,
   input  logic [31:0]      AO,
   input  logic [31:0]      DR,
   input  logic [31:0]      PCp4,
   input  logic             RegWrite,
   input  logic             MemtoReg,
   input  logic             Link,
   input  logic [4:0]       RA1,
   input  logic [4:0]       RA2,
   output logic [31:0]      RD1,
   output logic [31:0]      RD2,
   output logic [4:0]       WB_A3,
   output logic [31:0]      WB_WD,
   output logic             WB_WE,
   output logic [CNT_W-1:0] instret
);
   logic [31:0]      gpr_q [NREG];
   logic [CNT_W-1:0] instret_q, instret_d;
   logic [31:0]      ld_w;
   logic             byp1, byp2;

   load_ext u_load_ext (
      .dr_i   (DR),
      .addr_i (AO[1:0]),
      .op_i   (IR[31:26]),
      .ext_o  (ld_w)
   );

`ifdef WB_REG_BYPASS_EN
   assign byp1 = WB_WE && (RA1 == A3);
   assign byp2 = WB_WE && (RA2 == A3);
`else
   assign byp1 = 1'b0;
   assign byp2 = 1'b0;
`endif

   always_comb begin
      // Link returns past the delay slot, so PC+8
      WB_WD     = Link ? PCp4 + 32'd4 : MemtoReg ? ld_w : AO;
      WB_WE     = RegWrite && (A3 != REG_ZERO);
      WB_A3     = WB_WE ? A3 : REG_ZERO;
      instret_d = (IR != 32'h0) ? instret_q + CNT_W'(1) : instret_q;
      RD1       = (!reset || RA1 == REG_ZERO) ? 32'h0 : byp1 ? WB_WD : gpr_q[RA1];
      RD2       = (!reset || RA2 == REG_ZERO) ? 32'h0 : byp2 ? WB_WD : gpr_q[RA2];
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
         instret_q <= '0;
      end else begin
         if (WB_WE) gpr_q[A3] <= WB_WD;
         instret_q <= instret_d;
      end
   end

   assign instret = instret_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: table-driven write-back mux checks plus directed register-file sequences.
module tb_wb_regfile;
   logic        CLK = 1'b0, reset = 1'b1;
   logic [31:0] IR, AO, DR, PCp4;
   logic [4:0]  A3, RA1, RA2;
   logic        RegWrite, MemtoReg, Link;
   logic [31:0] RD1, RD2, WB_WD, instret;
   logic [4:0]  WB_A3;
   logic        WB_WE;
   int total = 0, bad = 0;

   wb_regfile dut (
      .CLK(CLK), .reset(reset), .IR(IR), .A3(A3), .AO(AO), .DR(DR), .PCp4(PCp4),
      .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Link(Link), .RA1(RA1), .RA2(RA2),
      .RD1(RD1), .RD2(RD2), .WB_A3(WB_A3), .WB_WD(WB_WD), .WB_WE(WB_WE), .instret(instret)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] ir, ao, dr, pcp4;
      logic [4:0]  a3;
      logic        rw, mtr, lnk;
      logic [31:0] wd;
      logic        we;
      logic [4:0]  a3o;
   } vec_t;

   vec_t v[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input logic [31:0] ir, input logic [4:0] a3, input logic [31:0] ao,
                        input logic rw, input logic mtr, input logic lnk, input logic [31:0] pcp4);
      IR = ir; A3 = a3; AO = ao; RegWrite = rw; MemtoReg = mtr; Link = lnk; PCp4 = pcp4;
   endtask

   task automatic bubble();
      drive(32'h0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
   endtask

   function automatic vec_t mk(input logic [5:0] op, input logic [31:0] ao, input logic [31:0] dr,
                               input logic [31:0] pcp4, input logic [4:0] a3, input logic rw,
                               input logic mtr, input logic lnk, input logic [31:0] wd,
                               input logic we, input logic [4:0] a3o);
      vec_t r;
      r.ir = {op, 26'h1}; r.ao = ao; r.dr = dr; r.pcp4 = pcp4; r.a3 = a3; r.rw = rw;
      r.mtr = mtr; r.lnk = lnk; r.wd = wd; r.we = we; r.a3o = a3o;
      return r;
   endfunction

   initial begin
      v[0]  = mk(6'h20, 32'h3, 32'h80FF_7F01, 32'h0, 5'd2, 1, 1, 0, 32'hFFFF_FF80, 1, 5'd2);
      v[1]  = mk(6'h24, 32'h3, 32'h80FF_7F01, 32'h0, 5'd2, 1, 1, 0, 32'h0000_0080, 1, 5'd2);
      v[2]  = mk(6'h21, 32'h2, 32'h80FF_7F01, 32'h0, 5'd3, 1, 1, 0, 32'hFFFF_80FF, 1, 5'd3);
      v[3]  = mk(6'h25, 32'h2, 32'h80FF_7F01, 32'h0, 5'd3, 1, 1, 0, 32'h0000_80FF, 1, 5'd3);
      v[4]  = mk(6'h20, 32'h0, 32'h80FF_7F01, 32'h0, 5'd4, 1, 1, 0, 32'h0000_0001, 1, 5'd4);
      v[5]  = mk(6'h20, 32'h1, 32'h80FF_7F01, 32'h0, 5'd4, 1, 1, 0, 32'h0000_007F, 1, 5'd4);
      v[6]  = mk(6'h21, 32'h0, 32'h80FF_7F01, 32'h0, 5'd4, 1, 1, 0, 32'h0000_7F01, 1, 5'd4);
      v[7]  = mk(6'h23, 32'h4, 32'h80FF_7F01, 32'h0, 5'd6, 1, 1, 0, 32'h80FF_7F01, 1, 5'd6);
      v[8]  = mk(6'h00, 32'h1, 32'h80FF_7F01, 32'h0, 5'd6, 1, 1, 0, 32'h80FF_7F01, 1, 5'd6);
      v[9]  = mk(6'h20, 32'h3, 32'h80FF_7F01, 32'h3004, 5'd31, 1, 1, 1, 32'h0000_3008, 1, 5'd31);
      v[10] = mk(6'h03, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd31, 1, 0, 1, 32'h0000_0000, 1, 5'd31);
      v[11] = mk(6'h00, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1, 0, 0, 32'hDEAD_BEEF, 0, 5'd0);
      v[12] = mk(6'h00, 32'h0000_1111, 32'h0, 32'h0, 5'd9, 0, 0, 0, 32'h0000_1111, 0, 5'd0);
      v[13] = mk(6'h25, 32'h3, 32'h80FF_7F01, 32'h0, 5'd8, 1, 1, 0, 32'h0000_80FF, 1, 5'd8);

      bubble(); DR = 32'h0; RA1 = 5'd5; RA2 = 5'd0;
      #2 reset = 1'b0;
      #1;
      chk("reset_rd1", RD1, 32'h0);
      chk("reset_instret", instret, 32'h0);

      // write-back mux is purely combinational, so run the table with reset held
      for (int i = 0; i < 14; i++) begin
         drive(v[i].ir, v[i].a3, v[i].ao, v[i].rw, v[i].mtr, v[i].lnk, v[i].pcp4);
         DR = v[i].dr;
         RA1 = v[i].a3;
         #3;
         chk($sformatf("vec%0d_wd", i), WB_WD, v[i].wd);
         chk($sformatf("vec%0d_we", i), {31'h0, WB_WE}, {31'h0, v[i].we});
         chk($sformatf("vec%0d_a3", i), {27'h0, WB_A3}, {27'h0, v[i].a3o});
         chk($sformatf("vec%0d_rd1_rst", i), RD1, 32'h0);
      end
      chk("held_instret", instret, 32'h0);

      bubble(); DR = 32'h0;
      @(negedge CLK) reset = 1'b1;
      tick();

      drive(32'h0000_0021, 5'd5, 32'h1234_5678, 1, 0, 0, 32'h0); RA1 = 5'd5;
      #1;
      chk("w5_we", {31'h0, WB_WE}, 32'h1);
`ifdef WB_REG_BYPASS_EN
      chk("w5_same_cycle", RD1, 32'h1234_5678);
`else
      chk("w5_same_cycle", RD1, 32'h0);
`endif
      tick(); bubble(); #1;
      chk("w5_rd1", RD1, 32'h1234_5678);
      chk("w5_instret", instret, 32'h1);

      drive(32'h0C00_0001, 5'd31, 32'h0, 1, 1, 0, 32'h0000_3004); Link = 1'b1; DR = 32'h5555_5555;
      tick(); bubble(); RA1 = 5'd31; #1;
      chk("link_r31", RD1, 32'h0000_3008);
      chk("link_instret", instret, 32'h2);

      drive(32'h0000_0021, 5'd0, 32'hDEAD_BEEF, 1, 0, 0, 32'h0); RA1 = 5'd0;
      #1;
      chk("a3zero_we", {31'h0, WB_WE}, 32'h0);
      chk("a3zero_a3", {27'h0, WB_A3}, 32'h0);
      tick(); bubble(); #1;
      chk("a3zero_rd1", RD1, 32'h0);
      chk("a3zero_instret", instret, 32'h3);

      drive(32'h0000_0021, 5'd7, 32'h1111_1111, 1, 0, 0, 32'h0);
      tick();
      drive(32'h0000_0021, 5'd7, 32'h2222_2222, 1, 0, 0, 32'h0); RA2 = 5'd7;
      #1;
`ifdef WB_REG_BYPASS_EN
      chk("rdw_same_cycle", RD2, 32'h2222_2222);
`else
      chk("rdw_same_cycle", RD2, 32'h1111_1111);
`endif
      tick(); bubble(); #1;
      chk("rdw_next_cycle", RD2, 32'h2222_2222);
      chk("rdw_instret", instret, 32'h5);

      RA1 = 5'd5;
      #2 reset = 1'b0;
      #1;
      chk("async_rd2", RD2, 32'h0);
      chk("async_rd1", RD1, 32'h0);
      chk("async_instret", instret, 32'h0);

      drive(32'h0000_0021, 5'd9, 32'h0000_0099, 1, 0, 0, 32'h0); RA1 = 5'd9;
      tick();
      @(negedge CLK);
      bubble(); reset = 1'b1;
      #1;
      chk("rst_write_dropped", RD1, 32'h0);
      chk("rst_count_dropped", instret, 32'h0);
      chk("rst_r7_cleared", RD2, 32'h0);

      drive(32'h0000_0021, 5'd9, 32'h0000_0099, 1, 0, 0, 32'h0);
      tick(); bubble(); #1;
      chk("release_write", RD1, 32'h0000_0099);
      chk("release_instret", instret, 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
